dense_layer: RTL and testbench



---
 rtl/dense_layer_if.sv | 31 +++
 rtl/dense_layer.sv | 135 +++++++++++++
 tb/tb_dense_layer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dense_layer_if.sv
// Signal bundle for dense_layer: input stream, output stream, weight/bias port and status.
// The master side is the controller/stream source; the slave side is the layer itself.
interface dense_layer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
);
  logic                  start;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_in;
  logic                  ready_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  ready_out;
  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  busy;
  logic                  done;

  // Handshakes: a word moves on a rising clk edge where valid and ready are both high.
  // valid_out and data_out hold steady until that edge; ready_in never depends on valid_in.
  modport master (
    output start, data_in, valid_in, ready_out, w_wr_en, w_addr, w_data,
    input  ready_in, data_out, valid_out, busy, done
  );

  modport slave (
    input  start, data_in, valid_in, ready_out, w_wr_en, w_addr, w_data,
    output ready_in, data_out, valid_out, busy, done
  );
endinterface

// File: rtl/dense_layer.sv
// Fully-connected layer: buffers IN_FEATURES Q8.8 inputs, then runs one shared MAC per
// output row (bias + dot product) and streams saturated Q8.8 results.
module dense_layer #(
  parameter int DATA_WIDTH   = 16,
  parameter int ACC_WIDTH    = 40,
  parameter int FRAC_BITS    = 8,
  parameter int IN_FEATURES  = 16,
  parameter int OUT_FEATURES = 1,
  parameter int ADDR_WIDTH   = $clog2(IN_FEATURES*OUT_FEATURES+OUT_FEATURES)
) (
  input  logic         clk,
  input  logic         rst,
  dense_layer_if.slave bus,
  output logic [2:0]   o_state
);
  localparam int NUM_W     = IN_FEATURES*OUT_FEATURES + OUT_FEATURES;
  localparam int BIAS_BASE = IN_FEATURES*OUT_FEATURES;
  localparam int IW = (IN_FEATURES > 1) ? $clog2(IN_FEATURES) : 1;
  localparam int JW = (OUT_FEATURES > 1) ? $clog2(OUT_FEATURES) : 1;
  localparam logic [IW-1:0]         I_LAST  = IW'(IN_FEATURES-1);
  localparam logic [JW-1:0]         J_LAST  = JW'(OUT_FEATURES-1);
  localparam logic [ADDR_WIDTH:0]   NUM_W_A = (ADDR_WIDTH+1)'(NUM_W);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2**(DATA_WIDTH-1))-1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -SAT_MAX - 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPUTE, S_OUTPUT, S_DONE} state_t;
  state_t r_state, w_next;

  logic signed [DATA_WIDTH-1:0] r_wmem [NUM_W];
  logic signed [DATA_WIDTH-1:0] r_buf  [IN_FEATURES];
  logic [IW-1:0]                r_i, r_k;
  logic [JW-1:0]                r_j;
  logic                         r_prime;
  logic signed [ACC_WIDTH-1:0]  r_acc;

  logic [ADDR_WIDTH-1:0]          w_widx, w_bidx;
  logic signed [DATA_WIDTH-1:0]   w_weight, w_bias, w_sat;
  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0]    w_prod_ext, w_bias_acc, w_shifted;
  logic                           w_wr_ok, w_valid_out;

  assign w_widx     = ADDR_WIDTH'(int'(r_j) * IN_FEATURES + int'(r_k));
  assign w_bidx     = ADDR_WIDTH'(BIAS_BASE + int'(r_j));
  assign w_weight   = r_wmem[w_widx];
  assign w_bias     = r_wmem[w_bidx];
  assign w_prod     = r_buf[r_k] * w_weight;
  assign w_prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};
  // Bias is Q8.8; the accumulator holds Q.16 products, so align it by FRAC_BITS.
  assign w_bias_acc = {{(ACC_WIDTH-DATA_WIDTH){w_bias[DATA_WIDTH-1]}}, w_bias} << FRAC_BITS;
  assign w_shifted  = r_acc >>> FRAC_BITS;
  assign w_wr_ok    = (r_state == S_IDLE) && bus.w_wr_en && ({1'b0, bus.w_addr} < NUM_W_A);

  always_comb begin
    w_sat = w_shifted[DATA_WIDTH-1:0];
    if (w_shifted > SAT_MAX)      w_sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (w_shifted < SAT_MIN) w_sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  end

  assign w_valid_out   = (r_state == S_OUTPUT);
  assign bus.valid_out = w_valid_out;
  assign bus.data_out  = w_valid_out ? w_sat : '0;
  assign bus.ready_in  = (r_state == S_LOAD);
  assign bus.busy      = (r_state == S_LOAD) || (r_state == S_COMPUTE) || (r_state == S_OUTPUT);
  assign bus.done      = (r_state == S_DONE);
  assign o_state       = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.start) w_next = S_LOAD;
      S_LOAD:    if (bus.valid_in && r_i == I_LAST) w_next = S_COMPUTE;
      S_COMPUTE: if (!r_prime && r_k == I_LAST) w_next = S_OUTPUT;
      S_OUTPUT:  if (bus.ready_out) w_next = (r_j == J_LAST) ? S_DONE : S_COMPUTE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // r_prime marks the extra cycle between rows that reloads the bias of the new row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NUM_W; n++) r_wmem[n] <= '0;
      for (int n = 0; n < IN_FEATURES; n++) r_buf[n] <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_prime <= 1'b0;
      r_acc   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_i     <= '0;
          r_j     <= '0;
          r_k     <= '0;
          r_prime <= 1'b0;
          if (w_wr_ok) r_wmem[bus.w_addr] <= bus.w_data;
        end
        S_LOAD: begin
          if (bus.valid_in) begin
            r_buf[r_i] <= bus.data_in;
            if (r_i == I_LAST) begin
              r_i   <= '0;
              r_k   <= '0;
              r_acc <= w_bias_acc;
            end else begin
              r_i <= r_i + 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          if (r_prime) begin
            r_acc   <= w_bias_acc;
            r_prime <= 1'b0;
          end else begin
            r_acc <= r_acc + w_prod_ext;
            r_k   <= (r_k == I_LAST) ? '0 : r_k + 1'b1;
          end
        end
        S_OUTPUT: begin
          if (bus.ready_out && r_j != J_LAST) begin
            r_j     <= r_j + 1'b1;
            r_k     <= '0;
            r_prime <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dense_layer.sv
// Bench for dense_layer (IN=4, OUT=2): arithmetic reference model feeds an expected queue,
// a negedge monitor pops it on every output handshake.
module tb_dense_layer;
  localparam int DW  = 16;
  localparam int IN  = 4;
  localparam int OUT = 2;
  localparam int NW  = IN*OUT + OUT;
  localparam int AW  = $clog2(NW);

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_exp;
  logic signed [DW-1:0] m_w  [NW];
  logic signed [DW-1:0] x_in [IN];

  dense_layer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  dense_layer #(
    .DATA_WIDTH(DW), .ACC_WIDTH(40), .FRAC_BITS(8),
    .IN_FEATURES(IN), .OUT_FEATURES(OUT), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .o_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done) done_cnt++;
      if (bus.valid_out && bus.ready_out) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %h expected none", bus.data_out);
        end else begin
          mon_exp = exp_q.pop_front();
          check("data_out", 32'(bus.data_out), 32'(mon_exp));
        end
      end
    end
  end

  // reference model: bias*2^8 + sum(x*w), floor-shift by 8, clamp to Q8.8
  function automatic logic [DW-1:0] model_out(input int j);
    longint acc;
    acc = longint'(m_w[IN*OUT + j]) * 256;
    for (int i = 0; i < IN; i++) acc += longint'(x_in[i]) * longint'(m_w[j*IN + i]);
    acc = acc >>> 8;
    if (acc > 32767)  return 16'h7FFF;
    if (acc < -32768) return 16'h8000;
    return acc[15:0];
  endfunction

  function automatic logic [DW-1:0] rnd_small();
    return 16'($urandom_range(0, 1023)) - 16'd512;
  endfunction

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input int addr, input logic [DW-1:0] data);
    bus.w_wr_en = 1'b1;
    bus.w_addr  = AW'(addr);
    bus.w_data  = data;
    cyc();
    bus.w_wr_en = 1'b0;
    if (addr < NW) m_w[addr] = data;
  endtask

  task automatic set_rows(input logic [DW-1:0] r0, input logic [DW-1:0] r1,
                          input logic [DW-1:0] b0, input logic [DW-1:0] b1);
    for (int i = 0; i < IN; i++) write_w(i, r0);
    for (int i = 0; i < IN; i++) write_w(IN + i, r1);
    write_w(IN*OUT, b0);
    write_w(IN*OUT + 1, b1);
  endtask

  task automatic poke();
    bus.start   = 1'b1;
    bus.w_wr_en = 1'b1;
    bus.w_addr  = AW'($urandom_range(0, NW-1));
    bus.w_data  = 16'($urandom);
  endtask

  task automatic unpoke();
    bus.start   = 1'b0;
    bus.w_wr_en = 1'b0;
  endtask

  task automatic feed_inputs(input int gap_pct, input bit perturb);
    for (int i = 0; i < IN; i++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        bus.valid_in = 1'b0;
        bus.data_in  = 16'($urandom);
        if (perturb) poke();
        cyc();
      end
      bus.valid_in = 1'b1;
      bus.data_in  = x_in[i];
      if (perturb) poke();
      check("ready_in_load", 32'(bus.ready_in), 32'd1);
      cyc();
    end
    bus.valid_in = 1'b0;
    check("ready_in_drop", 32'(bus.ready_in), 32'd0);
  endtask

  task automatic run_frame(input int gap_pct, input bit perturb, input bit bp);
    int cnt;
    int d0;
    logic [DW-1:0] held;
    for (int j = 0; j < OUT; j++) exp_q.push_back(model_out(j));
    d0 = done_cnt;
    bus.ready_out = !bp;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    feed_inputs(gap_pct, perturb);
    cnt = 0;
    while (!bus.valid_out && cnt < 200) begin
      if (perturb) poke();
      cyc();
      cnt++;
    end
    unpoke();
    check("first_latency", 32'(cnt), 32'(IN));
    if (bp) begin
      held = bus.data_out;
      for (int n = 0; n < 5; n++) begin
        cyc();
        check("bp_valid_hold", 32'(bus.valid_out), 32'd1);
        check("bp_data_hold", 32'(bus.data_out), 32'(held));
      end
      bus.ready_out = 1'b1;
    end else begin
      cyc();
      cnt = 0;
      while (!bus.valid_out && cnt < 200) begin
        cyc();
        cnt++;
      end
      check("next_latency", 32'(cnt), 32'(IN + 1));
    end
    cnt = 0;
    while (done_cnt == d0 && cnt < 200) begin
      cyc();
      cnt++;
    end
    repeat (3) cyc();
    check("done_pulses", 32'(done_cnt - d0), 32'd1);
    check("busy_after_done", 32'(bus.busy), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ready_in"},  32'(bus.ready_in),  32'd0);
    check({tag, "_valid_out"}, 32'(bus.valid_out), 32'd0);
    check({tag, "_data_out"},  32'(bus.data_out),  32'd0);
    check({tag, "_busy"},      32'(bus.busy),      32'd0);
    check({tag, "_done"},      32'(bus.done),      32'd0);
  endtask

  task automatic rand_setup();
    for (int n = 0; n < NW; n++) write_w(n, rnd_small());
    for (int i = 0; i < IN; i++) x_in[i] = rnd_small();
  endtask

  // main sequence
  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.data_in = '0; bus.valid_in = 1'b0; bus.ready_out = 1'b0;
    bus.w_wr_en = 1'b0; bus.w_addr = '0; bus.w_data = '0;
    for (int n = 0; n < NW; n++) m_w[n] = '0;
    repeat (3) cyc();
    check_quiet("rst_high");
    rst = 1'b0;
    cyc();
    check_quiet("rst_release");

    // all-ones weights, ramp input
    set_rows(16'h0100, 16'h0100, 16'h0000, 16'h0000);
    x_in[0] = 16'h0100; x_in[1] = 16'h0200; x_in[2] = 16'h0300; x_in[3] = 16'h0400;
    run_frame(0, 1'b0, 1'b0);

    // half / minus-one rows with bias on row 1
    set_rows(16'h0080, 16'hFF00, 16'h0000, 16'h0080);
    for (int i = 0; i < IN; i++) x_in[i] = 16'h0100;
    run_frame(0, 1'b0, 1'b0);

    // saturation at both rails
    set_rows(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    for (int i = 0; i < IN; i++) x_in[i] = 16'h7FFF;
    run_frame(0, 1'b0, 1'b0);
    set_rows(16'h8000, 16'h8000, 16'h0000, 16'h0000);
    run_frame(0, 1'b0, 1'b0);

    // random frames: clean, gapped, perturbed, back-pressured
    for (int t = 0; t < 3; t++) begin
      rand_setup();
      run_frame(0, 1'b0, 1'b0);
      run_frame(40, 1'b0, 1'b0);
      run_frame(30, 1'b1, 1'b0);
      run_frame($urandom_range(0, 30), 1'b0, 1'b1);
    end

    // out-of-range weight write
    rand_setup();
    write_w(NW, 16'h1234);
    write_w(NW + 3, 16'h7777);
    run_frame(0, 1'b0, 1'b0);

    // reset in the middle of COMPUTE, then a frame against cleared weights
    rand_setup();
    bus.ready_out = 1'b1;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    feed_inputs(0, 1'b0);
    cyc();
    check("busy_compute", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check_quiet("mid_rst");
    cyc();
    rst = 1'b0;
    check_quiet("mid_rst_release");
    for (int n = 0; n < NW; n++) m_w[n] = '0;
    exp_q.delete();
    for (int i = 0; i < IN; i++) x_in[i] = 16'($urandom);
    run_frame(20, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
